// File: rtl/matmul_controller.sv
// matmul_controller: sequences C = A x B for N x N matrices held in a shared
// registered-read memory. One memory access per cycle; a single MAC
// accumulates each C element before it is written back.
module matmul_controller #(
    parameter int N      = 2,
    parameter int SIZE   = 8,
    parameter int A_BASE = 0,
    parameter int B_BASE = 4,
    parameter int C_BASE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            mem_read,
    output logic [7:0]      mem_read_address,
    input  logic [SIZE-1:0] mem_data,
    output logic            mem_write,
    output logic [7:0]      mem_write_address,
    output logic [SIZE-1:0] mem_write_value
);

    localparam int            IW    = (N > 1) ? $clog2(N) : 1;
    localparam int            ACC_W = 2 * SIZE + $clog2(N);
    localparam logic [IW-1:0] LAST  = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_MAC,
        S_WR,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_i;
    logic [IW-1:0]    r_j;
    logic [IW-1:0]    r_k;
    logic [ACC_W-1:0] r_acc;
    logic [SIZE-1:0]  r_op_a;
    logic             r_busy;
    logic             r_done;
    logic             r_mem_read;
    logic [7:0]       r_rd_addr;
    logic             r_mem_write;
    logic [7:0]       r_wr_addr;
    logic [SIZE-1:0]  r_wr_val;

    logic [ACC_W-1:0] w_acc_next;
    logic [IW-1:0]    w_i_next;
    logic [IW-1:0]    w_j_next;
    logic             w_last_elem;

    // Row-major word address of element (row, col) of a matrix at base.
    function automatic logic [7:0] f_addr(input int base, input logic [IW-1:0] row,
                                          input logic [IW-1:0] col);
        return 8'(base + int'(row) * N + int'(col));
    endfunction

    // MAC result and row-major advance to the next C element.
    // The B operand is consumed straight from the read port in the MAC cycle.
    always_comb begin
        w_acc_next  = r_acc + (ACC_W'(r_op_a) * ACC_W'(mem_data));
        w_last_elem = (r_i == LAST) && (r_j == LAST);
        w_j_next    = (r_j == LAST) ? '0 : r_j + IW'(1);
        w_i_next    = (r_j == LAST) ? r_i + IW'(1) : r_i;
    end

    // Sequencer; outputs are registered for the state being entered, so the
    // strobes and addresses always match the state held in r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_op_a      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_rd_addr   <= '0;
            r_mem_write <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_val    <= '0;
        end else begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_rd_addr   <= '0;
            r_mem_write <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_val    <= '0;
            if (abort) begin
                // Also blocks start in IDLE; a WR in flight has already committed.
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state    <= S_RD_A;
                            r_i        <= '0;
                            r_j        <= '0;
                            r_k        <= '0;
                            r_acc      <= '0;
                            r_busy     <= 1'b1;
                            r_mem_read <= 1'b1;
                            r_rd_addr  <= f_addr(A_BASE, '0, '0);
                        end
                    end
                    S_RD_A: begin
                        r_state    <= S_RD_B;
                        r_busy     <= 1'b1;
                        r_mem_read <= 1'b1;
                        r_rd_addr  <= f_addr(B_BASE, r_k, r_j);
                    end
                    S_RD_B: begin
                        r_state <= S_MAC;
                        r_op_a  <= mem_data;
                        r_busy  <= 1'b1;
                    end
                    S_MAC: begin
                        r_acc  <= w_acc_next;
                        r_busy <= 1'b1;
                        if (r_k != LAST) begin
                            r_state    <= S_RD_A;
                            r_k        <= r_k + IW'(1);
                            r_mem_read <= 1'b1;
                            r_rd_addr  <= f_addr(A_BASE, r_i, r_k + IW'(1));
                        end else begin
                            r_state     <= S_WR;
                            r_mem_write <= 1'b1;
                            r_wr_addr   <= f_addr(C_BASE, r_i, r_j);
                            r_wr_val    <= w_acc_next[SIZE-1:0];
                        end
                    end
                    S_WR: begin
                        r_acc <= '0;
                        r_k   <= '0;
                        r_i   <= w_i_next;
                        r_j   <= w_j_next;
                        if (w_last_elem) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_RD_A;
                            r_busy     <= 1'b1;
                            r_mem_read <= 1'b1;
                            r_rd_addr  <= f_addr(A_BASE, w_i_next, '0);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign mem_read          = r_mem_read;
    assign mem_read_address  = r_rd_addr;
    assign mem_write         = r_mem_write;
    assign mem_write_address = r_wr_addr;
    assign mem_write_value   = r_wr_val;

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller: registered-read memory, a transaction-level
// model that expands each accepted start into the expected per-cycle output
// schedule, and directed tests with literal expectations.
module tb_matmul_controller;

    localparam int N  = 2;
    localparam int AB = 0;
    localparam int BB = 4;
    localparam int CB = 8;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       mem_read;
    logic [7:0] mem_read_address;
    logic [7:0] mem_data;
    logic       mem_write;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_value;

    matmul_controller #(
        .N(N), .SIZE(8), .A_BASE(AB), .B_BASE(BB), .C_BASE(CB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .mem_read(mem_read), .mem_read_address(mem_read_address),
        .mem_data(mem_data),
        .mem_write(mem_write), .mem_write_address(mem_write_address),
        .mem_write_value(mem_write_value)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory (registered read, write at edge) ----------------
    logic [7:0] mem [0:255];
    logic [7:0] rdata;
    logic       ld_en;
    logic [7:0] ld_a;
    logic [7:0] ld_v;
    logic [7:0] rlog [$];
    logic [7:0] wlog [$];

    assign mem_data = rdata;

    always @(posedge clk) begin
        if (ld_en) mem[ld_a] <= ld_v;
        if (mem_write) begin
            mem[mem_write_address] <= mem_write_value;
            wlog.push_back(mem_write_address);
        end
        if (mem_read) begin
            rdata <= mem[mem_read_address];
            rlog.push_back(mem_read_address);
        end
    end

    // ---------------- model: expected output schedule ----------------
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd;
        logic [7:0] ra;
        logic       wr;
        logic [7:0] wa;
        logic [7:0] wv;
    } exp_t;

    exp_t q [$];

    task automatic model_build();
        exp_t        e;
        int unsigned acc;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                acc = 0;
                for (int unsigned k = 0; k < N; k++) begin
                    e = '0; e.busy = 1'b1; e.rd = 1'b1; e.ra = 8'(AB + i * N + k);
                    q.push_back(e);
                    e.ra = 8'(BB + k * N + j);
                    q.push_back(e);
                    e = '0; e.busy = 1'b1;
                    q.push_back(e);
                    acc += int'(mem[AB + i * N + k]) * int'(mem[BB + k * N + j]);
                end
                e = '0; e.busy = 1'b1; e.wr = 1'b1;
                e.wa = 8'(CB + i * N + j); e.wv = 8'(acc);
                q.push_back(e);
            end
        end
        e = '0; e.done = 1'b1;
        q.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (q.size() > 0) begin
            void'(q.pop_front());
            if (abort) q.delete();
        end else if (start && !abort) begin
            model_build();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        exp_t e;
        exp_t a;
        if (q.size() > 0) e = q[0];
        else e = '0;
        a = {busy, done, mem_read, mem_read_address, mem_write, mem_write_address, mem_write_value};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL cycle_outputs @%0t: got busy=%b done=%b rd=%b ra=%0d wr=%b wa=%0d wv=%0d, expected busy=%b done=%b rd=%b ra=%0d wr=%b wa=%0d wv=%0d",
                     $time, a.busy, a.done, a.rd, a.ra, a.wr, a.wa, a.wv,
                     e.busy, e.done, e.rd, e.ra, e.wr, e.wa, e.wv);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int outs();
        return int'({busy, done, mem_read, mem_read_address, mem_write,
                     mem_write_address, mem_write_value});
    endfunction

    function automatic int wlog_at(input int idx);
        return (idx < wlog.size()) ? int'(wlog[idx]) : -1;
    endfunction

    function automatic int rlog_at(input int idx);
        return (idx < rlog.size()) ? int'(rlog[idx]) : -1;
    endfunction

    task automatic load_words(input logic [7:0] vals [12]);
        for (int unsigned w = 0; w < 12; w++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_a = 8'(w); ld_v = vals[w];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_c(input string tag, input int c0, input int c1, input int c2, input int c3);
        chk({tag, "_c0"}, int'(mem[CB + 0]), c0);
        chk({tag, "_c1"}, int'(mem[CB + 1]), c1);
        chk({tag, "_c2"}, int'(mem[CB + 2]), c2);
        chk({tag, "_c3"}, int'(mem[CB + 3]), c3);
    endtask

    // Pulse start; return the cycle index of done (start edge's cycle = 1) and busy cycles.
    task automatic run_op(output int done_idx, output int busy_cnt);
        int c0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 c0 = cyc;
        @(negedge clk); start = 1'b0;
        done_idx = -1;
        busy_cnt = 0;
        for (int t = 0; t < 200; t++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_idx = cyc - c0 + 1;
                break;
            end
            @(negedge clk);
        end
        if (done_idx < 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    // Start, then raise abort during cycle t_abort; report strobes seen in that cycle.
    task automatic abort_at(input int t_abort, output int st_rd, output int ra,
                            output int st_wr, output int wa);
        int c0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 c0 = cyc;
        @(negedge clk); start = 1'b0;
        while (cyc - c0 + 1 < t_abort) @(negedge clk);
        st_rd = int'(mem_read);  ra = int'(mem_read_address);
        st_wr = int'(mem_write); wa = int'(mem_write_address);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int didx, bcnt, w0, r0, nd, d1, d2, s_rd, s_ra, s_wr, s_wa;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        ld_en = 1'b0; ld_a = '0; ld_v = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_writes", wlog.size(), 0);
        chk("idle_reads", rlog.size(), 0);

        // Basic multiply
        load_words('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                     8'hEE, 8'hEE, 8'hEE, 8'hEE});
        w0 = wlog.size();
        run_op(didx, bcnt);
        chk("basic_done_cycle", didx, 29);
        chk("basic_busy_cycles", bcnt, 28);
        check_c("basic", 19, 22, 43, 50);
        for (int e = 0; e < 4; e++)
            chk($sformatf("basic_write_order%0d", e), wlog_at(w0 + e), CB + e);

        // Identity
        load_words('{8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6,
                     8'hEE, 8'hEE, 8'hEE, 8'hEE});
        r0 = rlog.size();
        run_op(didx, bcnt);
        check_c("ident", 9, 8, 7, 6);
        chk("ident_rd0", rlog_at(r0 + 0), 0);
        chk("ident_rd1", rlog_at(r0 + 1), 4);
        chk("ident_rd2", rlog_at(r0 + 2), 1);
        chk("ident_rd3", rlog_at(r0 + 3), 6);

        // Truncation
        load_words('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'hEE, 8'hEE, 8'hEE, 8'hEE});
        run_op(didx, bcnt);
        check_c("trunc", 2, 2, 2, 2);

        // start held high: back-to-back operations
        @(negedge clk); start = 1'b1;
        nd = 0; d1 = 0; d2 = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) d1 = cyc;
                else begin
                    d2 = cyc;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("held_done_count", nd, 2);
        chk("held_done_spacing", d2 - d1, 30);

        // Abort during third element's RD_B
        load_words('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                     8'hEE, 8'hEE, 8'hEE, 8'hEE});
        abort_at(16, s_rd, s_ra, s_wr, s_wa);
        chk("abort_rdb_strobe", s_rd, 1);
        chk("abort_rdb_addr", s_ra, 4);
        chk("abort_busy_low", int'(busy), 0);
        count_done(40, nd);
        chk("abort_no_done", nd, 0);
        check_c("abort_partial", 19, 22, 8'hEE, 8'hEE);
        run_op(didx, bcnt);
        chk("after_abort_done_cycle", didx, 29);
        check_c("after_abort", 19, 22, 43, 50);

        // Abort coinciding with the first WR still commits that write
        load_words('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                     8'hEE, 8'hEE, 8'hEE, 8'hEE});
        abort_at(7, s_rd, s_ra, s_wr, s_wa);
        chk("abort_wr_strobe", s_wr, 1);
        chk("abort_wr_addr", s_wa, 8);
        count_done(10, nd);
        chk("abort_wr_no_done", nd, 0);
        check_c("abort_wr", 19, 8'hEE, 8'hEE, 8'hEE);

        // Abort with start in IDLE: stays idle
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);
        count_done(5, nd);

        // Asynchronous reset mid-operation
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", outs(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_done(40, nd);
        chk("reset_no_done", nd, 0);
        run_op(didx, bcnt);
        chk("after_reset_done_cycle", didx, 29);
        check_c("after_reset", 19, 22, 43, 50);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matmul_controller.md
Name: matmul_controller

Overview:
Sequencer that computes C = A x B for N x N matrices held in the shared matrix memory. It issues one read per cycle over a registered-read port and accumulates products in an internal MAC. It writes each finished C element back through the memory write port. It sits between the top-level start/done handshake and the matrix memory, and is the memory's only master while busy.

Parameters:
N, 2, matrix dimension (A, B, C all N x N), legal 1..8
SIZE, 8, element width in bits (memory word width)
A_BASE, 0, word address of A[0][0]; row-major
B_BASE, 4, word address of B[0][0]; row-major
C_BASE, 8, word address of C[0][0]; row-major

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a multiply; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE, no done
busy  out  1  high while a multiply is in progress
done  out  1  one-cycle pulse after the last C write
mem_read  out  1  read strobe
mem_read_address  out  8  read word address
mem_data  in  SIZE  read data, valid the cycle after mem_read is high
mem_write  out  1  write strobe, committed at the rising edge
mem_write_address  out  8  write word address
mem_write_value  out  SIZE  write data

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0; i, j, k, accumulator and operand registers are 0.
- Internal accumulator width is 2*SIZE+clog2(N). Products are SIZE x SIZE unsigned. The stored result is the low SIZE bits of the accumulator (truncation, no saturation).
- States and transitions:
  - IDLE: if start=1, go to RD_A with i=j=k=0, acc=0, busy=1 from the next cycle.
  - RD_A: mem_read=1, mem_read_address=A_BASE+i*N+k; go to RD_B.
  - RD_B: mem_read=1, mem_read_address=B_BASE+k*N+j; capture mem_data into opA; go to MAC.
  - MAC: capture mem_data into opB, then acc += opA*opB (operands used as captured this cycle).
    - If k<N-1: k++, go to RD_A.
    - Else: go to WR.
  - WR: mem_write=1, mem_write_address=C_BASE+i*N+j, mem_write_value=acc[SIZE-1:0].
    - Clear acc and k.
    - Advance j; when j wraps N-1 to 0, advance i.
    - After writing element (N-1,N-1), go to DONE; otherwise go to RD_A.
  - DONE: done=1, busy=0; go to IDLE unconditionally.
- Strobes and addresses are decoded from the registered state. mem_read/mem_write are 0 outside their states, and addresses and write value are 0 when their strobe is low.
- Latency: start sampled at edge E0 gives done high in cycle N*N*(3N+1)+1 after E0. For N=2 that is 29, with busy high for 28 cycles.
- start is ignored while busy and during DONE; it is not queued.
- abort=1 in any non-IDLE state returns to IDLE at the next edge:
  - busy=0 and done stays 0;
  - a WR coinciding with abort still commits its write (the strobe is already asserted that cycle);
  - partial C contents are left as written.
- abort in IDLE has no effect; abort with start in IDLE gives abort priority (stay IDLE).
- rst mid-operation drops every output to 0 immediately; no completion is signalled.
- The memory must not be written or read by any other master while busy=1. The controller never reads a C address during an operation.

Test Plan:
- Reset then idle: assert rst mid-cycle -> all outputs 0 asynchronously; with start=0 for 20 cycles, no strobes and done=0.
- Basic multiply, N=2: A=[[1,2],[3,4]] at 0..3, B=[[5,6],[7,8]] at 4..7, pulse start -> writes 19,22,43,50 to addresses 8,9,10,11 in that order; done pulses exactly 29 cycles after the start edge; busy high for 28 cycles.
- Identity: A=I, B=[[9,8],[7,6]] -> C=[[9,8],[7,6]]; read address sequence per element is A,B,A,B (e.g. 0,4,1,6 for C[0][0]).
- Truncation: A and B all 255 -> every C word = 0x02 (130050 = 0x1FC02 low 8 bits).
- start held high continuously -> back-to-back operations, each producing one done pulse. The second operation begins in the cycle after DONE (IDLE samples start), with no start accepted while busy.
- Abort during the third element's RD_B -> busy low next cycle, no done; addresses 8,9 written and 10,11 unchanged. A following start then completes normally with the correct C.
